// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-schedule block.
//   state_e            : expansion FSM states (IDLE, GEN, DONE)
//   KEYLEN_*           : encodings of the 2-bit keylen input
//   RCON_SEED/RCON_POLY: Rcon start value and GF(2^8) reduction constant
//   xtime()            : GF(2^8) multiply-by-x used to advance Rcon
//   keylen_nk()        : key length in 32-bit words for a keylen code
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] KEYLEN_128 = 2'b00;
    localparam logic [1:0] KEYLEN_192 = 2'b01;
    localparam logic [1:0] KEYLEN_256 = 2'b10;
    localparam logic [1:0] KEYLEN_BAD = 2'b11;

    localparam logic [7:0] RCON_SEED = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    // The illegal code maps to 8 as well; callers reject it separately.
    function automatic logic [3:0] keylen_nk(input logic [1:0] kl);
        case (kl)
            KEYLEN_128: return 4'd4;
            KEYLEN_192: return 4'd6;
            default:    return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/sbox.sv
// Combinational AES forward S-box, one byte.
//   in_byte  : input byte
//   out_byte : SubBytes(in_byte)
module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 sits in the MSBs, so byte b occupies bits [8*(255-b)+7 -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // {~b, 3'b111} == 8*(255-b)+7
    assign out_byte = SBOX_TABLE[{~in_byte, 3'b111} -: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// AES key expansion (FIPS-197 KeyExpansion) for 128/192/256-bit keys.
// One expanded word is produced per clock; the full schedule is kept in
// word storage and read out four words at a time by round index.
//   int_osc   : clock, rising edge
//   reset     : asynchronous, active-high
//   load      : start request, honoured only in IDLE
//   keylen    : 00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   key       : cipher key, left-aligned (w[0] = key[255:224])
//   round     : round-key read index
//   rk        : {w[4r], w[4r+1], w[4r+2], w[4r+3]}, zero when round > Nr
//   busy      : expansion in progress
//   done      : one-cycle completion pulse
//   valid     : stored schedule is complete
//   err       : one-cycle pulse on a rejected load
//   state_dbg : current FSM state (state_e encoding)
//
// Handshake: load is a level sampled on each rising edge while IDLE; an
// accepted load starts the expansion and any load seen outside IDLE is
// dropped without side effects. done and err are single-cycle pulses and
// need no acknowledge.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic         int_osc,
    input  logic         reset,
    input  logic         load,
    input  logic [1:0]   keylen,
    input  logic [255:0] key,
    input  logic [3:0]   round,
    output logic [127:0] rk,
    output logic         busy,
    output logic         done,
    output logic         valid,
    output logic         err,
    output logic [1:0]   state_dbg
);

    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic [AW-1:0]   i_q, i_d;        // next word index to write
    logic [3:0]      j_q, j_d;        // i mod Nk, tracked incrementally
    logic [3:0]      nk_q, nk_d;
    logic [7:0]      rcon_q, rcon_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic [31:0]     w_q [0:DEPTH-1];

    logic [3:0]      load_nk;
    logic            load_ok;
    logic            accept;
    logic            gen_we;
    logic [AW-1:0]   prev_idx, back_idx, last_idx, rd_base;
    logic [31:0]     prev_w, back_w, sbox_in, sub_w, temp_w, new_w;
    logic [3:0]      nr;

    assign load_nk = keylen_nk(keylen);
    assign load_ok = (keylen != KEYLEN_BAD) && (int'(load_nk) <= MAX_NK);
    assign accept  = (state_q == ST_IDLE) && load && load_ok;

    // Operands of the recurrence w[i] = w[i-Nk] ^ temp.
    assign prev_idx = i_q - AW'(1);
    assign back_idx = i_q - AW'(nk_q);
    assign prev_w   = w_q[prev_idx];
    assign back_w   = w_q[back_idx];

    // Last word index is 4*(Nk+7)-1 = 4*Nk+27.
    assign last_idx = AW'({nk_q, 2'b00}) + AW'(27);

    // One S-box row serves both SubWord cases; RotWord only applies when
    // i mod Nk == 0.
    assign sbox_in = (j_q == 4'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    sbox u_sbox0 (.in_byte(sbox_in[31:24]), .out_byte(sub_w[31:24]));
    sbox u_sbox1 (.in_byte(sbox_in[23:16]), .out_byte(sub_w[23:16]));
    sbox u_sbox2 (.in_byte(sbox_in[15:8]),  .out_byte(sub_w[15:8]));
    sbox u_sbox3 (.in_byte(sbox_in[7:0]),   .out_byte(sub_w[7:0]));

    always_comb begin
        if (j_q == 4'd0) begin
            temp_w = sub_w ^ {rcon_q, 24'h0};
        end else if ((nk_q == 4'd8) && (j_q == 4'd4)) begin
            temp_w = sub_w;
        end else begin
            temp_w = prev_w;
        end
    end

    assign new_w = back_w ^ temp_w;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        nk_d    = nk_q;
        rcon_d  = rcon_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        gen_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    if (load_ok) begin
                        state_d = ST_GEN;
                        i_d     = AW'(load_nk);
                        j_d     = 4'd0;
                        nk_d    = load_nk;
                        rcon_d  = RCON_SEED;
                        valid_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GEN: begin
                gen_we = 1'b1;
                i_d    = i_q + AW'(1);
                j_d    = (j_q == nk_q - 4'd1) ? 4'd0 : j_q + 4'd1;
                if (j_q == 4'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == last_idx) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= 4'd0;
            nk_q    <= 4'd4;
            rcon_q  <= RCON_SEED;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            nk_q    <= nk_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Word storage is deliberately not reset; valid guards its contents.
    always_ff @(posedge int_osc) begin
        if (accept) begin
            w_q[0] <= key[255:224];
            w_q[1] <= key[223:192];
            w_q[2] <= key[191:160];
            w_q[3] <= key[159:128];
            if (load_nk > 4'd4) begin
                w_q[4] <= key[127:96];
                w_q[5] <= key[95:64];
            end
            if (load_nk > 4'd6) begin
                w_q[6] <= key[63:32];
                w_q[7] <= key[31:0];
            end
        end else if (gen_we) begin
            w_q[i_q] <= new_w;
        end
    end

    assign nr      = nk_q + 4'd6;
    assign rd_base = AW'({round, 2'b00});

    always_comb begin
        rk = 128'h0;
        if (round <= nr) begin
            rk = {w_q[rd_base], w_q[rd_base + AW'(1)],
                  w_q[rd_base + AW'(2)], w_q[rd_base + AW'(3)]};
        end
    end

    assign busy      = (state_q == ST_GEN);
    assign done      = (state_q == ST_DONE);
    assign valid     = valid_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
module tb_aes_key_schedule;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         load, load4;
  logic [1:0]   keylen;
  logic [255:0] key;
  logic [3:0]   round;
  logic [127:0] rk, rk4;
  logic         busy, done, valid, err;
  logic         busy4, done4, valid4, err4;
  logic [1:0]   state_dbg, state_dbg4;

  aes_key_schedule #(.MAX_NK(8)) dut (
    .int_osc(clk), .reset(reset), .load(load), .keylen(keylen), .key(key),
    .round(round), .rk(rk), .busy(busy), .done(done), .valid(valid),
    .err(err), .state_dbg(state_dbg)
  );

  aes_key_schedule #(.MAX_NK(4)) dut4 (
    .int_osc(clk), .reset(reset), .load(load4), .keylen(keylen), .key(key),
    .round(round), .rk(rk4), .busy(busy4), .done(done4), .valid(valid4),
    .err(err4), .state_dbg(state_dbg4)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;

  always @(negedge clk) if (err) err_seen++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (independent of the RTL table) ----------------
  logic [7:0]  sbox_ref [256];
  logic [31:0] ref_w [0:59];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox_ref[v[31:24]], sbox_ref[v[23:16]], sbox_ref[v[15:8]], sbox_ref[v[7:0]]};
  endfunction

  task automatic build_ref(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) ref_w[i] = 32'(k >> (32 * (7 - i)));
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  // Reads every round index, including the zero region above Nr.
  task automatic check_all(input int nk, input string tag);
    logic [127:0] exp;
    for (int r = 0; r < 16; r++) begin
      round = 4'(r);
      #1;
      if (r <= nk + 6) exp = {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
      else             exp = 128'h0;
      check($sformatf("%s rk[%0d]", tag, r), rk, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns 1 time unit after the accept edge.
  task automatic start_load(input logic [1:0] kl, input logic [255:0] k);
    @(negedge clk);
    keylen = kl;
    key    = k;
    load   = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen (bounded).
  // inject_at >= 0 raises a competing load for three cycles at that point.
  task automatic wait_done(input int inject_at, output int edges, output int busy_cnt);
    bit seen = 1'b0;
    edges    = 0;
    busy_cnt = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (c == 0) check("valid cleared on accept", valid, 1'b0);
      if (busy) busy_cnt++;
      if (edges == inject_at) begin
        load   = 1'b1;
        keylen = 2'b01;
        key    = {8{32'hdeadbeef}};
      end
      if (edges == inject_at + 3) load = 1'b0;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    load = 1'b0;
    check("done seen within bound", seen, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic [1:0]   kl;
    logic [255:0] k;
    logic [3:0]   rnd;
    logic [127:0] mask;
    logic [127:0] exp_rk;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int edges, bcnt, nk, err_base;
    logic [255:0] rkey;

    vecs[0] = '{"aes128 r10", 2'b00, K128, 4'd10, {128{1'b1}}, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{"aes128 r0",  2'b00, K128, 4'd0,  {128{1'b1}}, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[2] = '{"aes128 r1",  2'b00, K128, 4'd1,  {128{1'b1}}, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[3] = '{"aes128 r11", 2'b00, K128, 4'd11, {128{1'b1}}, 128'h0};
    vecs[4] = '{"aes192 w51", 2'b01, K192, 4'd12, {96'h0, 32'hffffffff}, {96'h0, 32'h01002202}};
    vecs[5] = '{"aes192 r13", 2'b01, K192, 4'd13, {128{1'b1}}, 128'h0};
    vecs[6] = '{"aes192 r1",  2'b01, K192, 4'd1,  {64'hffffffffffffffff, 64'h0}, {64'h62f8ead2522c6b7b, 64'h0}};
    vecs[7] = '{"aes256 r1",  2'b10, K256, 4'd1,  {128{1'b1}}, 128'h1f352c073b6108d72d9810a30914dff4};
    vecs[8] = '{"aes256 r15", 2'b10, K256, 4'd15, {128{1'b1}}, 128'h0};
    vecs[9] = '{"aes256 w59", 2'b10, K256, 4'd14, {96'h0, 32'hffffffff}, {96'h0, 32'h706c631e}};

    reset  = 1'b1;
    load   = 1'b0;
    load4  = 1'b0;
    keylen = 2'b00;
    key    = '0;
    round  = 4'd0;
    build_sbox();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",  busy, 1'b0);
    check("reset done",  done, 1'b0);
    check("reset valid", valid, 1'b0);
    check("reset err",   err, 1'b0);
    check("reset state", state_dbg, 2'd0);

    // Load presented as reset deasserts: accepted on the first edge
    keylen = 2'b00;
    key    = K128;
    load   = 1'b1;
    reset  = 1'b0;
    @(posedge clk);
    #1 load = 1'b0;
    check("accept on first edge after reset", busy, 1'b1);
    wait_done(-1, edges, bcnt);
    check("aes128 edges after reset", edges, 40);
    build_ref(K128, 4);
    check_all(4, "post-reset aes128");

    // Table-driven known answers
    for (int v = 0; v < 10; v++) begin
      nk = 4 + 2 * int'(vecs[v].kl);
      start_load(vecs[v].kl, vecs[v].k);
      wait_done(-1, edges, bcnt);
      check({vecs[v].name, " edges"}, edges, 3 * nk + 28);
      check({vecs[v].name, " busy cycles"}, bcnt, 3 * nk + 28);
      @(negedge clk);
      check({vecs[v].name, " done one cycle"}, done, 1'b0);
      check({vecs[v].name, " valid held"}, valid, 1'b1);
      round = vecs[v].rnd;
      #1;
      check(vecs[v].name, rk & vecs[v].mask, vecs[v].exp_rk);
    end

    // Illegal keylen with a valid AES-256 schedule stored
    err_base = err_seen;
    @(negedge clk);
    keylen = 2'b11;
    key    = {8{32'h12345678}};
    load   = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    check("illegal err pulse", err, 1'b1);
    check("illegal busy", busy, 1'b0);
    check("illegal valid kept", valid, 1'b1);
    @(posedge clk);
    #1;
    check("illegal err one cycle", err, 1'b0);
    check("illegal state idle", state_dbg, 2'd0);
    round = 4'd14;
    #1;
    check("illegal storage kept", rk[31:0], 32'h706c631e);
    check("illegal err count", err_seen - err_base, 1);

    // Competing load during GEN is ignored
    err_base = err_seen;
    start_load(2'b00, K128);
    wait_done(5, edges, bcnt);
    check("gen-load edges", edges, 40);
    check("gen-load no err", err_seen - err_base, 0);
    build_ref(K128, 4);
    check_all(4, "gen-load aes128");

    // Reset at GEN cycle 20, then a clean AES-256 run
    start_load(2'b10, K256);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort busy",  busy, 1'b0);
    check("abort done",  done, 1'b0);
    check("abort valid", valid, 1'b0);
    check("abort err",   err, 1'b0);
    check("abort state", state_dbg, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    start_load(2'b10, K256);
    wait_done(-1, edges, bcnt);
    check("post-abort edges", edges, 52);
    build_ref(K256, 8);
    check_all(8, "post-abort aes256");

    // MAX_NK=4 instance: AES-128 works, AES-256/illegal rejected
    @(negedge clk);
    keylen = 2'b00;
    key    = K128;
    load4  = 1'b1;
    @(posedge clk);
    #1 load4 = 1'b0;
    repeat (41) @(posedge clk);
    @(negedge clk);
    check("nk4 valid", valid4, 1'b1);
    round = 4'd10;
    #1;
    check("nk4 aes128 r10", rk4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      keylen = (t == 0) ? 2'b10 : 2'b11;
      key    = K256;
      load4  = 1'b1;
      @(posedge clk);
      #1 load4 = 1'b0;
      check($sformatf("nk4 reject %0d err", t), err4, 1'b1);
      check($sformatf("nk4 reject %0d busy", t), busy4, 1'b0);
      check($sformatf("nk4 reject %0d valid", t), valid4, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("nk4 reject %0d err cleared", t), err4, 1'b0);
      check($sformatf("nk4 reject %0d busy idle", t), busy4, 1'b0);
    end
    round = 4'd10;
    #1;
    check("nk4 storage kept", rk4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Random keys, every word against the reference model
    for (int len = 0; len < 3; len++) begin
      for (int n = 0; n < 100; n++) begin
        for (int b = 0; b < 8; b++) rkey[32*b +: 32] = $urandom();
        nk = 4 + 2 * len;
        start_load(2'(len), rkey);
        wait_done(-1, edges, bcnt);
        check($sformatf("rand len%0d #%0d edges", len, n), edges, 3 * nk + 28);
        build_ref(rkey, nk);
        check_all(nk, $sformatf("rand len%0d #%0d", len, n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
